// File: rtl/universal_ff_bank.sv
// Per-bit universal flip-flop bank (SR/JK/D/T by runtime mode) with an SR-forbidden hold-and-flag path.
// Latency one cycle from sampled inputs to all outputs. No backpressure; en=0 freezes q and err_cnt.
module universal_ff_bank #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic                 illegal,
  output logic [WIDTH-1:0]     illegal_bits,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     ill_bits_q, ill_bits_d;
  logic                 ill_q, ill_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d        = q_q;
    ill_bits_d = '0;
    if (en) begin
      case (mode)
        // S=R=1 holds because (a ^ b) is 0 there, keeping q_q.
        MODE_SR: begin
          q_d        = (a & ~b) | (q_q & ~(a ^ b));
          ill_bits_d = a & b;
        end
        MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
        MODE_D:  q_d = a;
        MODE_T:  q_d = q_q ^ a;
        default: q_d = q_q;
      endcase
    end
    ill_d = |ill_bits_d;
    cnt_d = cnt_q;
    if (ill_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q        <= RESET_VAL;
      ill_bits_q <= '0;
      ill_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      ill_bits_q <= ill_bits_d;
      ill_q      <= ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qbar         = ~q_q;
  assign illegal      = ill_q;
  assign illegal_bits = ill_bits_q;
  assign err_cnt      = cnt_q;

endmodule
